// File: rtl/bls12_381_pkg.sv
// bls12_381_pkg: BLS12-381 base-field constants, types, reference arithmetic and inversion-unit state encoding
package bls12_381_pkg;
   localparam int DAT_BITS = 381;
   typedef logic [DAT_BITS-1:0] fe_t;
   localparam fe_t P = fe_t'(384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab);
   localparam int FE_INV_MAX_CYCLES = 1536;
   typedef enum logic [1:0] {IDLE, RUN, OUT} fe_inv_state_t;

   function automatic fe_t fe_sub(fe_t a, fe_t b);
      return (b > a) ? a - b + P : a - b;
   endfunction

   function automatic fe_t fe_mul(fe_t a, fe_t b);
      logic [2*DAT_BITS-1:0] t;
      t = {{DAT_BITS{1'b0}}, a} * {{DAT_BITS{1'b0}}, b};
      return fe_t'(t % {{DAT_BITS{1'b0}}, P});
   endfunction

   // Fermat inverse a^(P-2); zero or out-of-range operands map to 0
   function automatic fe_t fe_inv(fe_t a);
      fe_t e, r;
      e = P - fe_t'(2);
      r = fe_t'(1);
      for (int i = DAT_BITS - 1; i >= 0; i--) begin
         r = fe_mul(r, r);
         if (e[i]) r = fe_mul(r, a);
      end
      return (a == '0 || a >= P) ? '0 : r;
   endfunction

   function automatic fe_t fe_div(fe_t b, fe_t a);
      return fe_mul(b, fe_inv(a));
   endfunction
endpackage

// File: rtl/bls12_381_fe_half_mod.sv
// bls12_381_fe_half_mod: x/2 mod P for x < P, held one bit wider so x+P cannot overflow
module bls12_381_fe_half_mod
   import bls12_381_pkg::*;
(
   input  logic [DAT_BITS:0] x,
   output logic [DAT_BITS:0] y
);
   logic [DAT_BITS:0] s;
   assign s = x[0] ? x + {1'b0, P} : x;
   assign y = s >> 1;
endmodule

// File: rtl/bls12_381_fe_inv_unit.sv
// bls12_381_fe_inv_unit: iterative Fp inverse by binary extended Euclid; BLS12_381_FE_INV_DIV_EN adds i_b for division
module bls12_381_fe_inv_unit
   import bls12_381_pkg::*;
#(
   parameter int CTL_BITS   = 8,
   parameter int MAX_CYCLES = FE_INV_MAX_CYCLES
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_val,
   output logic                o_rdy,
   input  logic [DAT_BITS-1:0] i_a,
`ifdef BLS12_381_FE_INV_DIV_EN
   input  logic [DAT_BITS-1:0] i_b,
`endif
   input  logic [CTL_BITS-1:0] i_ctl,
   output logic                o_val,
   input  logic                i_rdy,
   output logic [DAT_BITS-1:0] o_dat,
   output logic [CTL_BITS-1:0] o_ctl,
   output logic                o_err
);
   localparam int CW = $clog2(MAX_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);
   localparam fe_t ONE = fe_t'(1);

   fe_inv_state_t state, state_n;
   fe_t u, v, u_n, v_n, dat_n;
   logic [DAT_BITS:0] x1, x2, x1_n, x2_n, x1_h, x2_h, b0;
   logic [CW-1:0] cnt, cnt_n;
   logic [CTL_BITS-1:0] ctl_n;
   logic err_n, bad;

`ifdef BLS12_381_FE_INV_DIV_EN
   assign b0 = {1'b0, i_b};
`else
   assign b0 = {{DAT_BITS{1'b0}}, 1'b1};
`endif

   assign o_rdy = state == IDLE;
   assign o_val = state == OUT;

   bls12_381_fe_half_mod u_half1 (.x(x1), .y(x1_h));
   bls12_381_fe_half_mod u_half2 (.x(x2), .y(x2_h));

   // next state: load on accept, one Euclid step per RUN cycle, hold result in OUT until taken
   always_comb begin
      state_n = state;
      u_n     = u;
      v_n     = v;
      x1_n    = x1;
      x2_n    = x2;
      cnt_n   = cnt;
      dat_n   = o_dat;
      ctl_n   = o_ctl;
      err_n   = o_err;
      bad     = i_a == '0 || i_a >= P;
      if (state == IDLE) begin
         if (i_val) begin
            u_n     = i_a;
            v_n     = P;
            x1_n    = b0;
            x2_n    = '0;
            cnt_n   = '0;
            ctl_n   = i_ctl;
            dat_n   = '0;
            err_n   = bad;
            state_n = bad ? OUT : RUN;
         end
      end else if (state == RUN) begin
         cnt_n = cnt + 1'b1;
         if (u == ONE || v == ONE) begin
            dat_n   = (u == ONE) ? x1[DAT_BITS-1:0] : x2[DAT_BITS-1:0];
            err_n   = 1'b0;
            state_n = OUT;
         end else if (cnt == LAST) begin
            dat_n   = '0;
            err_n   = 1'b1;
            state_n = OUT;
         end else if (!u[0]) begin
            u_n  = u >> 1;
            x1_n = x1_h;
         end else if (!v[0]) begin
            v_n  = v >> 1;
            x2_n = x2_h;
         end else if (u >= v) begin
            u_n  = u - v;
            x1_n = (x2 > x1) ? x1 - x2 + {1'b0, P} : x1 - x2;
         end else begin
            v_n  = v - u;
            x2_n = (x1 > x2) ? x2 - x1 + {1'b0, P} : x2 - x1;
         end
      end else if (i_rdy) begin
         state_n = IDLE;
      end
   end

   // state and datapath registers; reset abandons any operation in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         u     <= '0;
         v     <= '0;
         x1    <= '0;
         x2    <= '0;
         cnt   <= '0;
         o_dat <= '0;
         o_ctl <= '0;
         o_err <= 1'b0;
      end else begin
         state <= state_n;
         u     <= u_n;
         v     <= v_n;
         x1    <= x1_n;
         x2    <= x2_n;
         cnt   <= cnt_n;
         o_dat <= dat_n;
         o_ctl <= ctl_n;
         o_err <= err_n;
      end
   end
endmodule

// File: tb/tb_bls12_381_fe_inv_unit.sv
// tb_bls12_381_fe_inv_unit: randomized bench; a result r is accepted when r < P and a*r mod P equals the numerator
module tb_bls12_381_fe_inv_unit;
   typedef logic [380:0] fe_t;
   localparam fe_t PM = fe_t'(384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab);
   localparam fe_t GX = fe_t'(384'h17f1d3a73197d7942695638c4fa9ac0fc3688c4f9774b905a14e3a3f171bac586c55e83ff97a1aeffb3af00adb22c6bb);
   localparam fe_t GY = fe_t'(384'h08b3f481e3aaa0f1a09e30ed741d8ae4fcf5e095d5d00af600db18cb2c04b3edd03cc744a2888ae40caa232946c5e7e1);

   logic i_clk = 1'b0, i_rst = 1'b1, i_val = 1'b0, i_rdy = 1'b1;
   logic o_rdy, o_val, o_err;
   fe_t i_a = '0, o_dat, numer = fe_t'(1);
   logic [7:0] i_ctl = '0, o_ctl;
   int total = 0, bad = 0, hs = 0;

`ifdef BLS12_381_FE_INV_DIV_EN
   fe_t i_b;
   assign i_b = numer;
`endif

   bls12_381_fe_inv_unit dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy), .i_a(i_a),
`ifdef BLS12_381_FE_INV_DIV_EN
      .i_b(i_b),
`endif
      .i_ctl(i_ctl), .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat), .o_ctl(o_ctl), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) if (!i_rst && o_val && i_rdy) hs <= hs + 1;

   function automatic fe_t mm(fe_t a, fe_t b);
      logic [761:0] t;
      t = {381'b0, a} * {381'b0, b};
      return fe_t'(t % {381'b0, PM});
   endfunction

   function automatic fe_t rnd_fe();
      logic [383:0] w;
      for (int i = 0; i < 12; i++) w[i*32 +: 32] = $urandom;
      w = w % {3'b0, PM};
      return (w == '0) ? fe_t'(1) : fe_t'(w);
   endfunction

   task automatic run_op(input fe_t a, input logic [7:0] ctl, output int lat);
      int n = 0;
      i_a = a;
      i_ctl = ctl;
      i_val = 1'b1;
      while (!o_rdy && n < 2000) begin @(posedge i_clk); #1; n++; end
      @(posedge i_clk); #1;
      i_val = 1'b0;
      lat = 1;
      while (!o_val && lat < 1600) begin @(posedge i_clk); #1; lat++; end
      total++;
      if (!o_val) begin bad++; $display("FAIL timeout: o_val=%b required 1 within %0d cycles", o_val, lat); end
   endtask

   task automatic drain();
      i_rdy = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      total += 5;
      if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", o_rdy); end
      if (o_val !== 1'b0) begin bad++; $display("FAIL reset_val: got %b want 0", o_val); end
      if (o_dat !== '0) begin bad++; $display("FAIL reset_dat: got %h want 0", o_dat); end
      if (o_ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl: got %h want 00", o_ctl); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", o_err); end
      i_rst = 1'b0;
   endtask

   task automatic test_one();
      int lat;
      run_op(fe_t'(1), 8'h5A, lat);
      total += 4;
      if (o_dat !== fe_t'(1)) begin bad++; $display("FAIL one_dat: got %h want 1", o_dat); end
      if (o_ctl !== 8'h5A) begin bad++; $display("FAIL one_ctl: got %h want 5a", o_ctl); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL one_err: got %b want 0", o_err); end
      if (lat != 2) begin bad++; $display("FAIL one_latency: got %0d want 2", lat); end
      drain();
      total += 2;
      if (o_val !== 1'b0) begin bad++; $display("FAIL one_drop: o_val got %b want 0", o_val); end
      if (o_rdy !== 1'b1) begin bad++; $display("FAIL one_idle: o_rdy got %b want 1", o_rdy); end
   endtask

   task automatic test_two();
      int lat;
      fe_t want;
      want = (PM + fe_t'(1)) >> 1;
      run_op(fe_t'(2), 8'h11, lat);
      total += 2;
      if (o_dat !== want) begin bad++; $display("FAIL two_dat: got %h want %h", o_dat, want); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL two_err: got %b want 0", o_err); end
      drain();
   endtask

   task automatic test_pm1();
      int lat;
      fe_t a;
      a = PM - fe_t'(1);
      run_op(a, 8'h22, lat);
      total += 2;
      if (o_dat !== a) begin bad++; $display("FAIL pm1_dat: got %h want %h", o_dat, a); end
      if (mm(a, o_dat) !== fe_t'(1)) begin bad++; $display("FAIL pm1_product: got %h want 1", mm(a, o_dat)); end
      drain();
   endtask

   task automatic test_err();
      fe_t vals [2];
      int lat;
      vals[0] = '0;
      vals[1] = PM;
      for (int k = 0; k < 2; k++) begin
         run_op(vals[k], 8'h30 + 8'(k), lat);
         total += 4;
         if (o_err !== 1'b1) begin bad++; $display("FAIL err%0d_err: got %b want 1", k, o_err); end
         if (o_dat !== '0) begin bad++; $display("FAIL err%0d_dat: got %h want 0", k, o_dat); end
         if (lat != 1) begin bad++; $display("FAIL err%0d_latency: got %0d want 1", k, lat); end
         if (o_ctl !== 8'h30 + 8'(k)) begin bad++; $display("FAIL err%0d_ctl: got %h want %h", k, o_ctl, 8'h30 + 8'(k)); end
         drain();
         total++;
         if (o_rdy !== 1'b1 || o_val !== 1'b0) begin bad++; $display("FAIL err%0d_idle: rdy=%b val=%b want rdy=1 val=0", k, o_rdy, o_val); end
      end
   endtask

   task automatic test_backpressure();
      int lat, flips;
      fe_t a, d0;
      logic [7:0] c0;
      a = rnd_fe();
      i_rdy = 1'b0;
      run_op(a, 8'h77, lat);
      d0 = o_dat;
      c0 = o_ctl;
      total += 2;
      if (mm(a, d0) !== fe_t'(1) || d0 >= PM) begin bad++; $display("FAIL bp_dat: got %h (product %h) want product 1", d0, mm(a, d0)); end
      if (c0 !== 8'h77) begin bad++; $display("FAIL bp_ctl: got %h want 77", c0); end
      flips = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge i_clk); #1;
         if (o_val !== 1'b1 || o_dat !== d0 || o_ctl !== c0 || o_rdy !== 1'b0) flips++;
      end
      total++;
      if (flips != 0) begin bad++; $display("FAIL bp_hold: %0d unstable cycles, want 0", flips); end
      drain();
      total++;
      if (o_val !== 1'b0) begin bad++; $display("FAIL bp_drop: o_val got %b want 0", o_val); end
   endtask

   task automatic test_reset_mid();
      int lat, hs0;
      i_a = GX;
      i_ctl = 8'hAA;
      i_val = 1'b1;
      @(posedge i_clk); #1;
      i_val = 1'b0;
      repeat (10) @(posedge i_clk);
      #1;
      total++;
      if (o_val !== 1'b0 || o_rdy !== 1'b0) begin bad++; $display("FAIL mid_busy: val=%b rdy=%b want val=0 rdy=0", o_val, o_rdy); end
      hs0 = hs;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      total++;
      if (o_rdy !== 1'b1 || o_val !== 1'b0) begin bad++; $display("FAIL mid_abandon: rdy=%b val=%b want rdy=1 val=0", o_rdy, o_val); end
      run_op(GY, 8'hC3, lat);
      total += 3;
      if (mm(GY, o_dat) !== fe_t'(1) || o_dat >= PM) begin bad++; $display("FAIL mid_dat: got %h want inverse of Gy", o_dat); end
      if (o_ctl !== 8'hC3) begin bad++; $display("FAIL mid_ctl: got %h want c3", o_ctl); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", o_err); end
      drain();
      total++;
      if (hs != hs0 + 1) begin bad++; $display("FAIL mid_count: results %0d want 1", hs - hs0); end
   endtask

   task automatic test_random(input int n);
      int lat, errs;
      fe_t a;
      logic [7:0] c;
      errs = 0;
      for (int k = 0; k < n; k++) begin
         a = rnd_fe();
         c = 8'($urandom);
`ifdef BLS12_381_FE_INV_DIV_EN
         numer = rnd_fe();
`endif
         run_op(a, c, lat);
         total++;
         if (o_err !== 1'b0 || o_ctl !== c || o_dat >= PM || mm(a, o_dat) !== numer) begin
            bad++;
            $display("FAIL rand%0d: a=%h got dat=%h ctl=%h err=%b want a*dat=%h ctl=%h err=0", k, a, o_dat, o_ctl, o_err, numer, c);
         end
         drain();
      end
      numer = fe_t'(1);
   endtask

   initial begin
      test_reset();
      test_one();
      test_two();
      test_pm1();
      test_err();
      test_backpressure();
      test_reset_mid();
      test_random(50);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
